oam_dma_arbiter: RTL

//   Sprite (OAM) DMA controller and CPU-bus arbiter. It sits between the CPU core and the memory map.
//   - A CPU write to the DMA register latches a source page. The block then stalls the CPU via rdy
//     and takes ownership of the bus.
//   - It copies XFER_LEN bytes from {page,8'h00}.. to the OAM data port as alternating read/write cycles.
//   - When idle, the block is a transparent pass-through of the CPU bus.
//

---
 rtl/oam_dma_arbiter.sv | 110 +++++++++++
 1 files changed

// File: rtl/oam_dma_arbiter.sv
// rtl/oam_dma_arbiter.sv - sprite OAM DMA engine and CPU bus arbiter
// Passes the CPU bus through when idle; otherwise stalls the CPU and copies one page to OAM.
module oam_dma_arbiter #(
   parameter logic [15:0] DMA_REG_ADDR  = 16'h4014,
   parameter logic [15:0] OAM_DATA_ADDR = 16'h2004,
   parameter int          XFER_LEN      = 256
) (
   input  logic        clk,
   input  logic        b_rst,
   input  logic [15:0] cpu_addr_out,
   input  logic [7:0]  cpu_data_out,
   input  logic        cpu_wen,
   input  logic        cpu_ren,
   input  logic [7:0]  mem_rdata,
   output logic        rdy,
   output logic [15:0] bus_addr,
   output logic [7:0]  bus_wdata,
   output logic        bus_wen,
   output logic        bus_ren,
   output logic        dma_busy
);

   typedef enum logic [2:0] {IDLE, HALT, ALIGN, READ, WRITE} state_t;

   localparam logic [7:0] LAST_OFFSET = 8'(XFER_LEN - 1);

   state_t     state;
   state_t     next_state;
   logic [7:0] page;
   logic [7:0] offset;
   logic [7:0] latch;
   logic       parity;
   logic       trigger;

   assign trigger  = (state == IDLE) && cpu_wen && (cpu_addr_out == DMA_REG_ADDR);
   assign dma_busy = (state != IDLE);

   always_ff @(posedge clk or negedge b_rst) begin
      if (!b_rst) begin
         state  <= IDLE;
         page   <= 8'h00;
         offset <= 8'h00;
         latch  <= 8'h00;
         parity <= 1'b0;
         rdy    <= 1'b1;
      end else begin
         state  <= next_state;
         parity <= ~parity;
         // rdy is registered from the next state so the CPU sees a clean stall edge
         rdy    <= (next_state == IDLE);
         if (trigger) begin
            page   <= cpu_data_out;
            offset <= 8'h00;
         end
         if (state == READ) begin
            latch <= mem_rdata;
         end
         if ((state == WRITE) && (offset != LAST_OFFSET)) begin
            offset <= offset + 8'h01;
         end
      end
   end

   always_comb begin
      next_state = state;
      bus_addr   = cpu_addr_out;
      bus_wdata  = cpu_data_out;
      bus_wen    = cpu_wen;
      bus_ren    = cpu_ren & ~cpu_wen;
      case (state)
         IDLE: begin
            if (trigger) begin
               next_state = HALT;
            end
         end
         HALT: begin
            bus_addr   = 16'h0000;
            bus_wdata  = 8'h00;
            bus_wen    = 1'b0;
            bus_ren    = 1'b0;
            next_state = parity ? ALIGN : READ;
         end
         ALIGN: begin
            bus_addr   = 16'h0000;
            bus_wdata  = 8'h00;
            bus_wen    = 1'b0;
            bus_ren    = 1'b0;
            next_state = READ;
         end
         READ: begin
            bus_addr   = {page, offset};
            bus_wdata  = 8'h00;
            bus_wen    = 1'b0;
            bus_ren    = 1'b1;
            next_state = WRITE;
         end
         WRITE: begin
            bus_addr   = OAM_DATA_ADDR;
            bus_wdata  = latch;
            bus_wen    = 1'b1;
            bus_ren    = 1'b0;
            next_state = (offset == LAST_OFFSET) ? IDLE : READ;
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

endmodule
